semafor_monitor: RTL

Passive checker for the two-head traffic-light controller: it samples the controller's RGB_A/RGB_B lamp buses, decodes each head's lamp state and flags conflicting greens, illegal codes or transitions, short green phases and stuck heads. It sits beside the controller in the same clock domain, on the receiving end of the RGB_A/RGB_B interface, and drives sticky error flags plus measurement outputs for the board LEDs and simulation benches.

---
 rtl/semafor_monitor.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/semafor_monitor.sv
// +--------------------------------------------------------------------------+
// | semafor_monitor: passive lamp-bus checker for the two-head light ctrl    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module semafor_monitor #(
  parameter int MIN_GREEN = 50,
  parameter int MAX_STUCK = 1000,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       RGB_A,
  input  logic [2:0]       RGB_B,
  input  logic             clr,
  output logic             err_conflict,
  output logic             err_seq,
  output logic             err_time,
  output logic             err_stuck,
  output logic [7:0]       err_cnt,
  output logic [CNT_W-1:0] green_len_a,
  output logic [CNT_W-1:0] green_len_b
);

  localparam logic [2:0]       RED       = 3'b100;
  localparam logic [2:0]       GREEN     = 3'b010;
  localparam logic [2:0]       YELLOW    = 3'b110;
  localparam logic [2:0]       OFF       = 3'b000;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_G     = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] STUCK_LIM = CNT_W'(MAX_STUCK);

  // index 0 is head A, index 1 is head B
  logic [1:0][2:0]       rgb_in;
  logic [1:0][2:0]       cur;
  logic [1:0][2:0]       prev;
  logic [1:0]            valid;
  logic [1:0]            prev_valid;
  logic [1:0]            track;
  logic [1:0][CNT_W-1:0] dwell;
  logic [1:0][CNT_W-1:0] stuck;
  logic [1:0][CNT_W-1:0] glen;

  logic [1:0] restart;
  logic [1:0] exit_green;
  logic [1:0] seq_ev;
  logic [1:0] time_ev;
  logic [1:0] stuck_ev;
  logic       conflict_ev;
  logic       any_ev;

  assign rgb_in = {RGB_B, RGB_A};

  function automatic logic legal_code(input logic [2:0] c);
    return (c == RED) || (c == GREEN) || (c == YELLOW) || (c == OFF);
  endfunction

  function automatic logic legal_step(input logic [2:0] p, input logic [2:0] c);
    return (p == c) ||
           (p == RED    && c == GREEN)  ||
           (p == GREEN  && c == YELLOW) ||
           (p == YELLOW && c == RED)    ||
           (p == YELLOW && c == OFF)    ||
           (p == OFF    && c == YELLOW) ||
           (p == OFF    && c == RED);
  endfunction

  always_comb begin
    restart    = '0;
    exit_green = '0;
    seq_ev     = '0;
    time_ev    = '0;
    stuck_ev   = '0;
    for (int h = 0; h < 2; h++) begin
      restart[h]    = !prev_valid[h] || (cur[h] != prev[h]);
      // a green first seen right after reset is a partial phase and is not measured
      exit_green[h] = prev_valid[h] && track[h] && (prev[h] == GREEN) && (cur[h] != GREEN);
      seq_ev[h]     = valid[h] && (!legal_code(cur[h]) ||
                      (prev_valid[h] && !legal_step(prev[h], cur[h])));
      time_ev[h]    = exit_green[h] && (dwell[h] < MIN_G);
      stuck_ev[h]   = (MAX_STUCK != 0) && valid[h] && !restart[h] &&
                      (stuck[h] == STUCK_LIM) && (stuck[h] != CNT_MAX);
    end
    conflict_ev = valid[0] && valid[1] &&
                  (((cur[0] == GREEN) && (cur[1] != RED)) ||
                   ((cur[1] == GREEN) && (cur[0] != RED)));
    any_ev = conflict_ev || (|seq_ev) || (|time_ev) || (|stuck_ev);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur          <= '0;
      prev         <= '0;
      valid        <= '0;
      prev_valid   <= '0;
      track        <= '0;
      dwell        <= '0;
      stuck        <= '0;
      glen         <= '0;
      err_conflict <= 1'b0;
      err_seq      <= 1'b0;
      err_time     <= 1'b0;
      err_stuck    <= 1'b0;
      err_cnt      <= 8'd0;
    end else begin
      cur        <= rgb_in;
      prev       <= cur;
      valid      <= 2'b11;
      prev_valid <= valid;

      for (int h = 0; h < 2; h++) begin
        if (valid[h]) begin
          if (cur[h] == GREEN) begin
            if (restart[h]) begin
              dwell[h] <= CNT_ONE;
              track[h] <= prev_valid[h];
            end else if (dwell[h] != CNT_MAX) begin
              dwell[h] <= dwell[h] + CNT_ONE;
            end
          end
          if (exit_green[h]) begin
            glen[h] <= dwell[h];
          end
          if (restart[h]) begin
            stuck[h] <= CNT_ONE;
          end else if (stuck[h] != CNT_MAX) begin
            stuck[h] <= stuck[h] + CNT_ONE;
          end
        end
      end

      // an event in the clr cycle survives the clear
      if (clr) begin
        err_conflict <= conflict_ev;
        err_seq      <= |seq_ev;
        err_time     <= |time_ev;
        err_stuck    <= |stuck_ev;
        err_cnt      <= {7'd0, any_ev};
      end else begin
        err_conflict <= err_conflict | conflict_ev;
        err_seq      <= err_seq | (|seq_ev);
        err_time     <= err_time | (|time_ev);
        err_stuck    <= err_stuck | (|stuck_ev);
        if (any_ev && (err_cnt != 8'hFF)) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

  assign green_len_a = glen[0];
  assign green_len_b = glen[1];

endmodule

`default_nettype wire
